// File: rtl/wt_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// wt_mem_req_arbiter
//
// Shares the single memory-side request port between three requesters:
//   0 : instruction-cache refill
//   1 : write-through data-cache read miss
//   2 : data-cache write buffer (stores)
// Allocates memory transaction IDs (TIDs), limits the number of stores in
// flight and routes responses back to their originator by TID.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   req_i[3]         per-requester request valid (bit 2 = store requester)
//   addr_i           per-requester address, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt_o[3]         one-hot grant, high in the handshake cycle only
//   wbuf_fill_i      write-buffer occupancy (store urgency)
//   mem_req_valid_o  memory request valid
//   mem_req_ready_i  memory port accepts the request
//   mem_req_addr_o   address of the selected requester
//   mem_req_we_o     high when the selected requester is the store requester
//   mem_req_tid_o    TID allocated to the request
//   mem_rsp_valid_i  memory response valid (always accepted)
//   mem_rsp_tid_i    TID carried by the response
//   rsp_valid_o[3]   one-hot response strobe to the TID owner
//   tid_busy_o       TID in-use vector (debug)
//   err_o            sticky: a response arrived on a free TID
//
// Handshake: a memory request transfers on a cycle where mem_req_valid_o and
// mem_req_ready_i are both high. Once valid is raised it is held, together
// with addr/we/tid, until that transfer happens (the LOCKED state). Responses
// have no back-pressure: mem_rsp_valid_i is consumed in the cycle it is high.
// ---------------------------------------------------------------------------
module wt_mem_req_arbiter #(
  parameter int unsigned MEM_TID_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned MAX_OUT_STORES = 7,
  parameter int unsigned WBUF_DEPTH     = 8,
  parameter int unsigned WBUF_URGENT    = 6,
  localparam int unsigned NUM_TID       = 2 ** MEM_TID_WIDTH,
  localparam int unsigned FILL_W        = $clog2(WBUF_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0]                 req_i,
  input  logic [3*ADDR_WIDTH-1:0]    addr_i,
  output logic [2:0]                 gnt_o,
  input  logic [FILL_W-1:0]          wbuf_fill_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr_o,
  output logic                       mem_req_we_o,
  output logic [MEM_TID_WIDTH-1:0]   mem_req_tid_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [MEM_TID_WIDTH-1:0]   mem_rsp_tid_i,
  output logic [2:0]                 rsp_valid_o,
  output logic [NUM_TID-1:0]         tid_busy_o,
  output logic                       err_o
);

  localparam int unsigned          CNT_W       = $clog2(MAX_OUT_STORES + 1);
  localparam logic [CNT_W-1:0]     MAX_CNT     = CNT_W'(MAX_OUT_STORES);
  localparam logic [FILL_W-1:0]    URGENT_FILL = FILL_W'(WBUF_URGENT);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // registers
  state_e                    r_state;
  logic [1:0]                r_winner;
  logic [MEM_TID_WIDTH-1:0]  r_tid;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [1:0]                r_rr_ptr;
  logic [NUM_TID-1:0]        r_busy;
  logic [1:0]                r_owner [NUM_TID];
  logic [CNT_W-1:0]          r_store_cnt;
  logic                      r_err;

  // wires
  state_e                    w_state_nxt;
  logic                      w_any_free;
  logic [MEM_TID_WIDTH-1:0]  w_free_tid;
  logic                      w_store_ok;
  logic [2:0]                w_elig;
  logic                      w_urgent;
  logic [1:0]                w_rr_sel;
  logic                      w_rr_found;
  logic [2:0]                w_rr_idx;
  logic [1:0]                w_sel_idle;
  logic                      w_valid;
  logic [1:0]                w_winner;
  logic [MEM_TID_WIDTH-1:0]  w_tid;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic                      w_hs;
  logic                      w_lock;
  logic                      w_rsp_busy;
  logic                      w_rsp_hit;
  logic                      w_rsp_err;
  logic [1:0]                w_rsp_owner;
  logic                      w_store_inc;
  logic                      w_store_dec;

  function automatic logic [ADDR_WIDTH-1:0] f_sel_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    f_sel_addr = addr_i[0*ADDR_WIDTH +: ADDR_WIDTH];
      2'd1:    f_sel_addr = addr_i[1*ADDR_WIDTH +: ADDR_WIDTH];
      default: f_sel_addr = addr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Eligibility and selection
  // ---------------------------------------------------------------------
  assign w_any_free = ~(&r_busy);
  assign w_store_ok = (r_store_cnt < MAX_CNT);
  assign w_elig     = req_i & {3{w_any_free}} & {w_store_ok, 2'b11};
  assign w_urgent   = w_elig[2] && (wbuf_fill_i >= URGENT_FILL);

  // Lowest free TID. Uses the registered table only, so a TID freed by a
  // response this cycle is not reused until the next cycle.
  always_comb begin
    w_free_tid = '0;
    for (int i = NUM_TID - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_tid = MEM_TID_WIDTH'(i);
    end
  end

  // Round-robin search starting at the pointer: ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    w_rr_sel   = r_rr_ptr;
    w_rr_found = 1'b0;
    w_rr_idx   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      w_rr_idx = {1'b0, r_rr_ptr} + 3'(k);
      if (w_rr_idx >= 3'd3) w_rr_idx = w_rr_idx - 3'd3;
      if (!w_rr_found && w_elig[w_rr_idx[1:0]]) begin
        w_rr_sel   = w_rr_idx[1:0];
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_sel_idle = w_urgent ? 2'd2 : w_rr_sel;

  // ---------------------------------------------------------------------
  // FSM: next state and request outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_valid     = 1'b0;
    w_winner    = r_winner;
    w_tid       = r_tid;
    w_addr      = r_addr;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_valid  = |w_elig;
        w_winner = w_sel_idle;
        w_tid    = w_free_tid;
        w_addr   = f_sel_addr(w_sel_idle);
      end
      ST_LOCKED: begin
        w_valid = 1'b1;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
    // Combinational outputs must read zero while reset is held, even if a
    // requester keeps req_i high through reset.
    w_valid = w_valid & rst_ni;
    if (w_valid && mem_req_ready_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_valid) begin
      w_state_nxt = ST_LOCKED;
    end
  end

  assign w_hs   = w_valid & mem_req_ready_i;
  assign w_lock = (r_state == ST_IDLE) & w_valid & ~mem_req_ready_i;

  assign mem_req_valid_o = w_valid;
  assign mem_req_addr_o  = w_valid ? w_addr : '0;
  assign mem_req_we_o    = w_valid && (w_winner == 2'd2);
  assign mem_req_tid_o   = w_valid ? w_tid : '0;
  assign gnt_o           = w_hs ? (3'b001 << w_winner) : 3'b000;

  // ---------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------
  assign w_rsp_busy  = r_busy[mem_rsp_tid_i];
  assign w_rsp_owner = r_owner[mem_rsp_tid_i];
  assign w_rsp_hit   = rst_ni & mem_rsp_valid_i & w_rsp_busy;
  assign w_rsp_err   = mem_rsp_valid_i & ~w_rsp_busy;
  assign rsp_valid_o = w_rsp_hit ? (3'b001 << w_rsp_owner) : 3'b000;

  assign tid_busy_o  = r_busy;
  assign err_o       = r_err;

  assign w_store_inc = w_hs && (w_winner == 2'd2);
  assign w_store_dec = w_rsp_hit && (w_rsp_owner == 2'd2);

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_winner <= 2'd0;
      r_tid    <= '0;
      r_addr   <= '0;
      r_rr_ptr <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      // The TID chosen here stays reserved for the locked request; it is
      // only committed to the table at the handshake.
      if (w_lock) begin
        r_winner <= w_winner;
        r_tid    <= w_tid;
        r_addr   <= w_addr;
      end
      // Pointer advances past the winner, urgent wins included.
      if (w_hs) begin
        r_rr_ptr <= (w_winner == 2'd2) ? 2'd0 : (w_winner + 2'd1);
      end
    end
  end

  // A TID being granted is free and a TID being freed is busy, so the set
  // and clear below never target the same entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_TID; i++) r_owner[i] <= 2'd0;
    end else begin
      if (w_hs) begin
        r_busy[w_tid]  <= 1'b1;
        r_owner[w_tid] <= w_winner;
      end
      if (w_rsp_hit) begin
        r_busy[mem_rsp_tid_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_store_cnt <= '0;
    end else begin
      case ({w_store_inc, w_store_dec})
        2'b10:   r_store_cnt <= r_store_cnt + CNT_W'(1);
        2'b01:   r_store_cnt <= r_store_cnt - CNT_W'(1);
        default: r_store_cnt <= r_store_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_rsp_err) begin
      r_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------
  a_store_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_store_inc && !w_store_dec && (r_store_cnt == MAX_CNT)));

  a_store_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_store_dec && !w_store_inc && (r_store_cnt == '0)));

  a_locked_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_LOCKED) |-> (req_i[r_winner] && (f_sel_addr(r_winner) == r_addr)));

endmodule
